// File: rtl/pci_arb_pkg.sv
// pci_arb_pkg
// Shared definitions for the parameterised PCI bus arbiter:
//   arb_state_e - arbiter FSM states (park, turnaround gap, grant, bus busy)
//   MODE_RR / MODE_FIXED - arbitration mode selectors
//   CNT_W - width of the idle-bus timeout counter (covers IDLE_TIMEOUT up to 255)
//   wrap_inc() - modular increment used to start the round-robin search
package pci_arb_pkg;

    typedef enum logic [1:0] {
        StPark  = 2'd0,
        StGap   = 2'd1,
        StGrant = 2'd2,
        StBusy  = 2'd3
    } arb_state_e;

    localparam int unsigned MODE_RR    = 0;
    localparam int unsigned MODE_FIXED = 1;

    localparam int unsigned CNT_W = 8;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/pci_arbiter_param_if.sv
// pci_arbiter_param_if
// Bundles the PCI arbitration signals (all PCI-side signals active-low).
//   FRAME, IRDY  - bus activity, driven by the current bus master
//   REQ          - per-master request
//   GNT          - per-master grant (registered in the arbiter)
//   OWNER        - index of the current or most recently granted master
//   TIMEOUT_EVT  - one-clock pulse when a grant is revoked for not starting
// Modports: master = agents on the bus, slave = the arbiter.
interface pci_arbiter_param_if #(
    parameter int unsigned NUM_MASTERS = 4
);
    localparam int unsigned IdxW = $clog2(NUM_MASTERS);

    logic                   FRAME;
    logic                   IRDY;
    logic [NUM_MASTERS-1:0] REQ;
    logic [NUM_MASTERS-1:0] GNT;
    logic [IdxW-1:0]        OWNER;
    logic                   TIMEOUT_EVT;

    modport master (
        output FRAME,
        output IRDY,
        output REQ,
        input  GNT,
        input  OWNER,
        input  TIMEOUT_EVT
    );

    modport slave (
        input  FRAME,
        input  IRDY,
        input  REQ,
        output GNT,
        output OWNER,
        output TIMEOUT_EVT
    );

endinterface

// File: rtl/pci_arb_pick.sv
// pci_arb_pick
// Combinational rotate-priority encoder.
//   req_i   - active-high request vector
//   start_i - first index searched in rotating mode (search wraps N-1 -> 0)
//   fixed_i - 1: ignore start_i, lowest index wins
//   valid_o - at least one request present
//   idx_o   - winning index
module pci_arb_pick #(
    parameter  int unsigned NUM_MASTERS = 4,
    localparam int unsigned IdxW        = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IdxW-1:0]        start_i,
    input  logic                   fixed_i,
    output logic                   valid_o,
    output logic [IdxW-1:0]        idx_o
);

    int unsigned base;
    int unsigned cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 32'd0;
        base    = fixed_i ? 32'd0 : 32'(start_i);
        // Walk offsets 0..N-1 from base; first hit is the winner.
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            cand = (base + k) % NUM_MASTERS;
            if (!valid_o && req_i[IdxW'(cand)]) begin
                valid_o = 1'b1;
                idx_o   = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/pci_arbiter_param.sv
// pci_arbiter_param
// Parameterised PCI central arbiter with bus parking, turnaround gap, hidden
// arbitration during a transaction and an idle-bus grant timeout.
//   CLK    - PCI clock, rising edge
//   RESET  - synchronous, active-low
//   bus    - slave side of pci_arbiter_param_if (FRAME/IRDY/REQ in, GNT/OWNER/TIMEOUT_EVT out)
// Parameters: NUM_MASTERS (2..16), MODE (MODE_RR / MODE_FIXED), PARK_MASTER,
// IDLE_TIMEOUT (2..255 idle clocks allowed before an unused grant is revoked).
module pci_arbiter_param
    import pci_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS  = 4,
    parameter int unsigned MODE         = MODE_RR,
    parameter int unsigned PARK_MASTER  = 0,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input logic                CLK,
    input logic                RESET,
    pci_arbiter_param_if.slave bus
);

    localparam int unsigned      IdxW       = $clog2(NUM_MASTERS);
    localparam logic [IdxW-1:0]  ParkIdx    = IdxW'(PARK_MASTER);
    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(IDLE_TIMEOUT);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [IdxW-1:0]        winner_q, winner_d;
    logic [IdxW-1:0]        rr_q, rr_d;       // last granted index
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   seen_q, seen_d;   // bus sampled idle since grant
    logic                   tevt_q, tevt_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] own_mask;
    logic [NUM_MASTERS-1:0] pick_req;
    logic                   bus_idle;
    logic                   any_req;
    logic                   own_req;
    logic                   pick_valid;
    logic [IdxW-1:0]        pick_start;
    logic [IdxW-1:0]        pick_idx;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   rearb;

    function automatic logic [NUM_MASTERS-1:0] gnt_for(input logic [IdxW-1:0] idx);
        return ~(NUM_MASTERS'(1) << idx);
    endfunction

    assign req        = ~bus.REQ;
    assign bus_idle   = bus.FRAME & bus.IRDY;
    assign any_req    = |req;
    assign own_req    = req[owner_q];
    // A master losing its grant in GRANT must not win the re-arbitration it caused.
    assign own_mask   = (state_q == StGrant) ? (NUM_MASTERS'(1) << owner_q) : '0;
    assign pick_req   = req & ~own_mask;
    assign pick_start = IdxW'(wrap_inc(32'(rr_q), NUM_MASTERS));
    assign cnt_inc    = cnt_q + 1'b1;

    pci_arb_pick #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_pick (
        .req_i   (pick_req),
        .start_i (pick_start),
        .fixed_i (MODE == MODE_FIXED),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        winner_d = winner_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        tevt_d   = 1'b0;
        rearb    = 1'b0;

        unique case (state_q)
            StPark: begin
                if (pick_valid) begin
                    if (pick_idx == ParkIdx) begin
                        // Parked master already drives the bus; no turnaround needed.
                        state_d = StGrant;
                        owner_d = pick_idx;
                        rr_d    = pick_idx;
                        cnt_d   = '0;
                        seen_d  = 1'b0;
                    end else begin
                        state_d  = StGap;
                        gnt_d    = '1;
                        winner_d = pick_idx;
                    end
                end
            end
            StGap: begin
                state_d = StGrant;
                gnt_d   = gnt_for(winner_q);
                owner_d = winner_q;
                rr_d    = winner_q;
                cnt_d   = '0;
                seen_d  = 1'b0;
            end
            StGrant: begin
                if (bus_idle) begin
                    seen_d = 1'b1;
                end
                if (!bus.FRAME && seen_q) begin
                    state_d = StBusy;
                    cnt_d   = '0;
                end else if (!own_req) begin
                    rearb = 1'b1;
                end else if (bus_idle && cnt_inc == TimeoutCnt) begin
                    tevt_d = 1'b1;
                    rr_d   = owner_q;
                    rearb  = 1'b1;
                end else if (bus_idle) begin
                    cnt_d = cnt_inc;
                end
            end
            StBusy: begin
                // Round-robin search starts past the owner, so the owner only wins
                // when nobody else asks; in fixed mode it keeps GNT while it has priority.
                if (pick_valid && pick_idx != owner_q) begin
                    state_d = StGrant;
                    gnt_d   = gnt_for(pick_idx);
                    owner_d = pick_idx;
                    rr_d    = pick_idx;
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                end else if (!any_req && bus_idle) begin
                    state_d = StPark;
                    gnt_d   = gnt_for(ParkIdx);
                    owner_d = ParkIdx;
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                end
            end
            default: begin
                state_d = StPark;
            end
        endcase

        if (rearb) begin
            if (pick_valid) begin
                state_d  = StGap;
                gnt_d    = '1;
                winner_d = pick_idx;
            end else begin
                state_d = StPark;
                gnt_d   = gnt_for(ParkIdx);
                owner_d = ParkIdx;
                cnt_d   = '0;
                seen_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= StPark;
            gnt_q    <= gnt_for(ParkIdx);
            owner_q  <= ParkIdx;
            winner_q <= ParkIdx;
            rr_q     <= '0;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            tevt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            winner_q <= winner_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            tevt_q   <= tevt_d;
        end
    end

    assign bus.GNT         = gnt_q;
    assign bus.OWNER       = owner_q;
    assign bus.TIMEOUT_EVT = tevt_q;

endmodule

// File: tb/tb_pci_arbiter_param.sv
// tb_pci_arbiter_param
// Drives a round-robin and a fixed-priority arbiter with identical bus stimulus.
// Each stimulus step pushes the expected post-edge GNT/OWNER/TIMEOUT_EVT into a
// queue; a monitor pops and compares shortly after the following rising edge.
module tb_pci_arbiter_param;
    import pci_arb_pkg::*;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] own;
        logic       tev;
        bit         fx_chk;
        logic [3:0] fx_gnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame = 1'b1;
    logic       irdy = 1'b1;
    logic [3:0] req = 4'hF;

    int    n_vec = 0;
    int    n_miss = 0;
    exp_t  exp_q[$];
    string tag_q[$];
    exp_t  cur;
    string cur_tag;
    int    rr_seq [5] = '{1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    pci_arbiter_param_if #(.NUM_MASTERS(4)) rr_if ();
    pci_arbiter_param_if #(.NUM_MASTERS(4)) fx_if ();

    assign rr_if.FRAME = frame;
    assign rr_if.IRDY  = irdy;
    assign rr_if.REQ   = req;
    assign fx_if.FRAME = frame;
    assign fx_if.IRDY  = irdy;
    assign fx_if.REQ   = req;

    pci_arbiter_param #(
        .NUM_MASTERS(4), .MODE(MODE_RR), .PARK_MASTER(0), .IDLE_TIMEOUT(16)
    ) dut_rr (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (rr_if)
    );

    pci_arbiter_param #(
        .NUM_MASTERS(4), .MODE(MODE_FIXED), .PARK_MASTER(0), .IDLE_TIMEOUT(16)
    ) dut_fx (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (fx_if)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Active-low grant pattern for master m.
    function automatic logic [3:0] gv(input int m);
        return ~(4'b0001 << m);
    endfunction

    // Apply one clock of stimulus; expectations describe outputs after the next edge.
    // efx < 0 leaves the fixed-priority instance unchecked.
    task automatic drive(input string tag, input logic rst, input logic fr, input logic ir,
                         input logic [3:0] rq, input logic [3:0] eg, input int eo,
                         input logic et, input int efx);
        exp_t e;
        @(negedge clk);
        rst_n = rst;
        frame = fr;
        irdy  = ir;
        req   = rq;
        e.gnt    = eg;
        e.own    = 2'(eo);
        e.tev    = et;
        e.fx_chk = (efx >= 0);
        e.fx_gnt = 4'(efx);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            cur     = exp_q.pop_front();
            cur_tag = tag_q.pop_front();
            check_eq({cur_tag, ".gnt"}, 32'(rr_if.GNT), 32'(cur.gnt));
            check_eq({cur_tag, ".owner"}, 32'(rr_if.OWNER), 32'(cur.own));
            check_eq({cur_tag, ".tevt"}, 32'(rr_if.TIMEOUT_EVT), 32'(cur.tev));
            if (cur.fx_chk) begin
                check_eq({cur_tag, ".fx_gnt"}, 32'(fx_if.GNT), 32'(cur.fx_gnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset defaults on both instances.
        drive("rst0", 0, 1, 1, 4'hF, 4'hE, 0, 0, 14);
        drive("rst1", 0, 1, 1, 4'hF, 4'hE, 0, 0, 14);

        // Master 2 from park: one all-high clock, grant, idle, start, finish, park.
        drive("m2_gap",   1, 1, 1, 4'b1011, 4'hF,  0, 0, -1);
        drive("m2_gnt",   1, 1, 1, 4'b1011, gv(2), 2, 0, -1);
        drive("m2_idle",  1, 1, 1, 4'b1011, gv(2), 2, 0, -1);
        drive("m2_start", 1, 0, 1, 4'b1011, gv(2), 2, 0, -1);
        drive("m2_norq",  1, 0, 0, 4'hF,    gv(2), 2, 0, -1);
        drive("m2_last",  1, 1, 0, 4'hF,    gv(2), 2, 0, -1);
        drive("m2_park",  1, 1, 1, 4'hF,    4'hE,  0, 0, -1);

        // All masters requesting: RR order 1,2,3,0,1; fixed instance keeps master 0.
        drive("rr_rst",  0, 1, 1, 4'hF, 4'hE,  0, 0, 14);
        drive("rr_gap",  1, 1, 1, 4'h0, 4'hF,  0, 0, 14);
        drive("rr_gnt1", 1, 1, 1, 4'h0, gv(1), 1, 0, 14);
        for (int i = 0; i < 4; i++) begin
            drive("rr_idle",  1, 1, 1, 4'h0, gv(rr_seq[i]),   rr_seq[i],   0, 14);
            drive("rr_start", 1, 0, 1, 4'h0, gv(rr_seq[i]),   rr_seq[i],   0, 14);
            drive("rr_hand",  1, 0, 0, 4'h0, gv(rr_seq[i+1]), rr_seq[i+1], 0, 14);
            drive("rr_tail",  1, 1, 0, 4'h0, gv(rr_seq[i+1]), rr_seq[i+1], 0, 14);
        end

        // Master 3 never starts: revoked after 16 idle clocks, master 1 next.
        drive("to_rst",  0, 1, 1, 4'hF,    4'hE,  0, 0, -1);
        drive("to_gap",  1, 1, 1, 4'b0111, 4'hF,  0, 0, -1);
        drive("to_gnt3", 1, 1, 1, 4'b0111, gv(3), 3, 0, -1);
        for (int i = 0; i < 8; i++) drive("to_idle_a", 1, 1, 1, 4'b0101, gv(3), 3, 0, -1);
        for (int i = 0; i < 3; i++) drive("to_nonidle", 1, 1, 0, 4'b0101, gv(3), 3, 0, -1);
        for (int i = 0; i < 7; i++) drive("to_idle_b", 1, 1, 1, 4'b0101, gv(3), 3, 0, -1);
        drive("to_expire", 1, 1, 1, 4'b0101, 4'hF,  3, 1, -1);
        drive("to_next",   1, 1, 1, 4'b0101, gv(1), 1, 0, -1);

        // Hidden arbitration 1 -> 2 during busy; master 2 must see idle before busy.
        drive("hd_rst",     0, 1, 1, 4'hF,    4'hE,  0, 0, -1);
        drive("hd_gap",     1, 1, 1, 4'b1101, 4'hF,  0, 0, -1);
        drive("hd_gnt1",    1, 1, 1, 4'b1101, gv(1), 1, 0, -1);
        drive("hd_idle",    1, 1, 1, 4'b1101, gv(1), 1, 0, -1);
        drive("hd_start",   1, 0, 1, 4'b1101, gv(1), 1, 0, -1);
        drive("hd_move",    1, 0, 0, 4'b1001, gv(2), 2, 0, -1);
        drive("hd_nostart", 1, 0, 0, 4'b1011, gv(2), 2, 0, -1);
        drive("hd_drop",    1, 1, 0, 4'hF,    4'hE,  0, 0, -1);

        // Reset during a busy transaction wins over every transition.
        drive("rb_rst",   0, 1, 1, 4'hF,    4'hE,  0, 0, -1);
        drive("rb_gap",   1, 1, 1, 4'b1101, 4'hF,  0, 0, -1);
        drive("rb_gnt1",  1, 1, 1, 4'b1101, gv(1), 1, 0, -1);
        drive("rb_idle",  1, 1, 1, 4'b1101, gv(1), 1, 0, -1);
        drive("rb_start", 1, 0, 1, 4'b1101, gv(1), 1, 0, -1);
        drive("rb_reset", 0, 0, 0, 4'b1101, 4'hE,  0, 0, -1);

        // Granted master drops REQ with another pending: gap then new grant.
        drive("dp_gap",  1, 1, 1, 4'b1101, 4'hF,  0, 0, -1);
        drive("dp_gnt1", 1, 1, 1, 4'b1101, gv(1), 1, 0, -1);
        drive("dp_swap", 1, 1, 1, 4'b1011, 4'hF,  1, 0, -1);
        drive("dp_gnt2", 1, 1, 1, 4'b1011, gv(2), 2, 0, -1);
        // Master 2 times out with nobody else waiting: straight back to park.
        for (int i = 0; i < 15; i++) drive("tp_idle", 1, 1, 1, 4'b1011, gv(2), 2, 0, -1);
        drive("tp_expire", 1, 1, 1, 4'b1011, 4'hE, 0, 1, -1);
        drive("tp_after",  1, 1, 1, 4'hF,    4'hE, 0, 0, -1);

        @(negedge clk);
        @(negedge clk);
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pci_arbiter_param.md
PCI_ARBITER_PARAM -- requirements
Module: pci_arbiter_param

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of REQ#/GNT# pairs, legal range 2..16.
REQ-002 Parameter MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-003 Parameter PARK_MASTER, default 0: master granted when no REQ is asserted.
REQ-004 Parameter IDLE_TIMEOUT, default 16: idle-bus clocks a granted master has to start FRAME# before its grant is revoked; range 2..255.
REQ-005 CLK  input  1  PCI clock; all logic on rising edge.
REQ-006 RESET  input  1  synchronous, active-low reset.
REQ-007 FRAME  input  1  PCI FRAME#, active-low.
REQ-008 IRDY  input  1  PCI IRDY#, active-low.
REQ-009 REQ  input  NUM_MASTERS  per-master REQ#, active-low.
REQ-010 GNT  output  NUM_MASTERS  per-master GNT#, active-low, registered.
REQ-011 OWNER  output  $clog2(NUM_MASTERS)  index of the current or last granted master, registered.
REQ-012 TIMEOUT_EVT  output  1  one-clock pulse when a grant is revoked by timeout.

Function
REQ-013 Bus idle SHALL be FRAME==1 && IRDY==1, sampled at the rising edge.
REQ-014 At most one GNT bit SHALL be low in any cycle.
REQ-015 The FSM SHALL have four states: PARK, GAP, GRANT, BUSY.
REQ-016 PARK: GNT[PARK_MASTER]=0. Any REQ low -> pick a winner. Winner==PARK_MASTER -> GRANT with no gap. Otherwise -> GAP.
REQ-017 GAP: all GNT high for exactly one clock, then GRANT to the latched winner.
REQ-018 GRANT: GNT[winner]=0. Set flag seen_idle when the bus is sampled idle. FRAME==0 while seen_idle==1 -> BUSY, and the timeout counter clears.
REQ-019 GRANT timeout: the counter SHALL increment only on idle-bus clocks.
REQ-020 GRANT timeout expiry: counter == IDLE_TIMEOUT -> pulse TIMEOUT_EVT, move the round-robin pointer past the winner, go to GAP if other REQs are pending, else go to PARK.
REQ-021 BUSY, other master requesting: the arbiter SHALL move GNT directly from the owner to the new winner in one clock (hidden arbitration, no gap), enter GRANT, and clear seen_idle.
REQ-022 BUSY, only the owner requesting: the owner SHALL keep GNT.
REQ-023 BUSY, no REQ asserted: the arbiter SHALL go to PARK once the bus is sampled idle.
REQ-024 Round-robin: the search SHALL start at (last granted index + 1) mod NUM_MASTERS and wrap from NUM_MASTERS-1 to 0.
REQ-025 Fixed priority: the lowest index with REQ low SHALL win.
REQ-026 Winner selection SHALL be combinational from REQ; GNT updates one clock later (registered).
REQ-027 A master dropping REQ while in GRANT, before starting, SHALL have GNT removed on the next clock, then re-arbitrate (GAP, or PARK if no REQ).
REQ-028 OWNER SHALL update on the same clock as GNT.

Reset
REQ-029 While RESET==0 at a clock edge: state = PARK, GNT = all ones except bit PARK_MASTER low, OWNER = PARK_MASTER, RR pointer = 0, counter = 0, TIMEOUT_EVT = 0.
REQ-030 Reset asserted mid-transaction SHALL take priority over all transitions on that edge.

Structure
REQ-031 Shared package pci_arb_pkg SHALL hold the state enumeration and the MODE_RR/MODE_FIXED constants.
REQ-032 One sub-module, pci_arb_pick, SHALL implement the combinational rotate-priority encoder.
   - Inputs: request vector, start index, mode.
   - Outputs: valid, index.

Verification
REQ-033 Reset, no REQ -> GNT=4'b1110, OWNER=0 (defaults).
REQ-034 REQ=4'b1011 from PARK -> one clock with GNT=4'b1111, then GNT=4'b1011.
   - Master 2 drives FRAME=0 after an idle clock -> BUSY.
REQ-035 MODE=0, all four REQ held low, each master runs one transaction -> grant order 1,2,3,0,1 (wraps).
   - MODE=1 with the same stimulus -> master 0 is granted repeatedly.
REQ-036 GRANT to master 3, bus idle, FRAME never asserted -> TIMEOUT_EVT pulses after 16 idle clocks.
   - GNT[3] then goes high, and the next requester is granted after the GAP clock.
REQ-037 Master 1 in BUSY with FRAME low, REQ[2] asserts -> GNT moves 1→2 with no all-high clock.
   - Master 2 does not reach BUSY until the bus has been idle one clock.
REQ-038 RESET=0 during BUSY with GNT[1]=0 -> the next edge gives GNT=4'b1110 and no TIMEOUT_EVT.
